// File: rtl/iaoq_ctrl_pkg.sv
// Shared definitions for the instruction address offset queue controller:
// FSM state encoding, default geometry and the link-address offset.
package iaoq_ctrl_pkg;

    // Sequential flow vs. "a redirect was just applied, delay slot in front".
    typedef enum logic {
        SEQ   = 1'b0,
        DSLOT = 1'b1
    } iaoq_state_e;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_STEP   = 4;

    // Return address skips the branch and its delay slot.
    localparam int LINK_OFS   = 8;

endpackage : iaoq_ctrl_pkg

// File: rtl/iaoq_ctrl.sv
// Two-entry instruction address offset queue (front/back) with a one-deep
// pending-redirect buffer for branches that resolve during a stall, and a
// two-state FSM that blocks a second redirect while a delay slot is in front.
module iaoq_ctrl
    import iaoq_ctrl_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int STEP        = DEF_STEP,
    parameter int RESET_FRONT = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              LE,
    input  logic              TAKEN,
    input  logic [ADDR_W-1:0] TA,
    input  logic              NULLIFY_REQ,
    output logic [ADDR_W-1:0] IAOQ_FRONT,
    output logic [ADDR_W-1:0] IAOQ_BACK,
    output logic              NULL_FRONT,
    output logic [ADDR_W-1:0] LINK_ADDR,
    output logic              IN_DSLOT,
    output logic              REDIR_DROP
);

    localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] RESET_V = ADDR_W'(RESET_FRONT);
    localparam logic [ADDR_W-1:0] LINK_V  = ADDR_W'(LINK_OFS);

    iaoq_state_e       r_state;
    iaoq_state_e       w_state_nxt;

    logic [ADDR_W-1:0] r_front;
    logic [ADDR_W-1:0] r_back;
    logic              r_null;
    logic              r_pend_valid;
    logic [ADDR_W-1:0] r_pend_ta;
    logic              r_redir_drop;

    logic [ADDR_W-1:0] w_front_nxt;
    logic [ADDR_W-1:0] w_back_nxt;
    logic              w_null_nxt;
    logic              w_pend_valid_nxt;
    logic [ADDR_W-1:0] w_pend_ta_nxt;
    logic              w_redir_drop_nxt;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_target;

    // State register for the SEQ/DSLOT FSM.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SEQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, redirect selection and buffer update; priority on advance is
    // live TAKEN, then the pending buffer, then the sequential address.
    // NOTE: every signal gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt      = r_state;
        w_front_nxt      = r_front;
        w_back_nxt       = r_back;
        w_null_nxt       = r_null;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_ta_nxt    = r_pend_ta;
        w_redirect       = 1'b0;
        w_target         = r_back + STEP_V;
        // A branch resolving while the delay slot is in front is dropped,
        // stalled or not; the pulse is registered to keep outputs off inputs.
        w_redir_drop_nxt = (r_state == DSLOT) && TAKEN;

        unique case (r_state)
            SEQ: begin
                if (LE) begin
                    if (TAKEN) begin
                        w_redirect = 1'b1;
                        w_target   = TA;
                    end else if (r_pend_valid) begin
                        w_redirect = 1'b1;
                        w_target   = r_pend_ta;
                    end
                end else if (TAKEN) begin
                    // Latest stalled branch wins.
                    w_pend_valid_nxt = 1'b1;
                    w_pend_ta_nxt    = TA;
                end
            end
            DSLOT: begin
                // Redirects are never taken or buffered here.
            end
        endcase

        if (LE) begin
            w_front_nxt      = r_back;
            w_back_nxt       = w_target;
            w_null_nxt       = NULLIFY_REQ;
            w_pend_valid_nxt = 1'b0;
            w_state_nxt      = ((r_state == SEQ) && w_redirect) ? DSLOT : SEQ;
        end
    end

    // Queue, nullify flag, pending buffer and drop pulse registers.
    // NOTE: the pending target is reset alongside its valid flag so a stale
    // address can never be observed after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_front      <= RESET_V;
            r_back       <= RESET_V + STEP_V;
            r_null       <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_ta    <= '0;
            r_redir_drop <= 1'b0;
        end else begin
            r_front      <= w_front_nxt;
            r_back       <= w_back_nxt;
            r_null       <= w_null_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_ta    <= w_pend_ta_nxt;
            r_redir_drop <= w_redir_drop_nxt;
        end
    end

    assign IAOQ_FRONT = r_front;
    assign IAOQ_BACK  = r_back;
    assign NULL_FRONT = r_null;
    assign LINK_ADDR  = r_front + LINK_V;
    assign IN_DSLOT   = (r_state == DSLOT);
    assign REDIR_DROP = r_redir_drop;

endmodule : iaoq_ctrl
